// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, FSM state encoding and helpers shared by alu_seq.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_LUI  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_SLT  = 4'b1100;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_REMU = 4'b1010;

   // Iterative-unit mode matches optr[1:0] of the MULU/DIVU/REMU opcodes.
   localparam logic [1:0] MD_MUL = 2'b00;
   localparam logic [1:0] MD_DIV = 2'b01;
   localparam logic [1:0] MD_REM = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_multicycle(input logic [3:0] optr);
      return (optr == OP_MULU) || (optr == OP_DIVU) || (optr == OP_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// alu_muldiv_iter : one-bit-per-cycle unsigned shift-add multiply and
//                   restoring divide/remainder; done/result are combinational
//                   on the final iteration so the caller can register them.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;

   always_comb begin
      acc_d    = acc_q;
      mq_d     = mq_q;
      md_d     = md_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      mode_d   = mode_q;
      rem_sh   = {acc_q, mq_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, md_q};
      if (start) begin
         acc_d  = '0;
         mq_d   = a;
         md_d   = b;
         mode_d = mode;
         cnt_d  = CNT_W'(WIDTH);
         busy_d = 1'b1;
      end else if (busy_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
         if (mode_q == MD_MUL) begin
            acc_d = acc_q + (mq_q[0] ? md_q : '0);
            md_d  = md_q << 1;
            mq_d  = mq_q >> 1;
         // Bit WIDTH of the difference is the borrow: set means "restore".
         end else if (!rem_diff[WIDTH]) begin
            acc_d = rem_diff[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = rem_sh[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign done   = busy_q && (cnt_q == CNT_W'(1));
   assign result = (mode_q == MD_DIV) ? mq_d : acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         mq_q   <= '0;
         md_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         mode_q <= MD_MUL;
      end else begin
         acc_q  <= acc_d;
         mq_q   <= mq_d;
         md_q   <= md_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         mode_q <= mode_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : handshaked, registered ALU with optional iterative MULU/DIVU/REMU
//           (enabled by defining ALU_SEQ_MULDIV_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       optr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ret,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ret_q, ret_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] alu_ret;
   logic             alu_ovf;
   logic             alu_err;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic [CNT_W-2:0] sh;
   logic             md_done;
   logic [WIDTH-1:0] md_result;

   assign sum = a + b;
   assign dif = a - b;
   assign sh  = b[CNT_W-2:0];

   always_comb begin
      alu_ret = '0;
      alu_ovf = 1'b0;
      alu_err = 1'b0;
      case (optr)
         OP_ADD: begin
            alu_ret = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_ret = dif;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_ret = a & b;
         OP_OR:   alu_ret = a | b;
         OP_XOR:  alu_ret = a ^ b;
         OP_LUI:  alu_ret = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_SLL:  alu_ret = a << sh;
         OP_SRL:  alu_ret = a >> sh;
         OP_SRA:  alu_ret = $unsigned($signed(a) >>> sh);
         OP_SLT:  alu_ret = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         // MULU/DIVU/REMU land here when the iterative unit is absent.
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   logic md_start;
   assign md_start = in_valid && in_ready && is_multicycle(optr);

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .a      (a),
      .b      (b),
      .mode   (optr[1:0]),
      .done   (md_done),
      .result (md_result)
   );
`else
   assign md_done   = 1'b0;
   assign md_result = '0;
`endif

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
               if (is_multicycle(optr)) begin
                  state_d = ST_BUSY;
               end else
`endif
               begin
                  state_d = ST_DONE;
                  ret_d   = alu_ret;
                  zero_d  = (alu_ret == '0);
                  ovf_d   = alu_ovf;
                  err_d   = alu_err;
               end
            end
         end
         ST_BUSY: begin
            if (md_done) begin
               state_d = ST_DONE;
               ret_d   = md_result;
               zero_d  = (md_result == '0);
               ovf_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ret_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign ret       = ret_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule

`default_nettype wire
